iterative_mul_unit: RTL and testbench
=====================================

// Module: iterative_mul_unit
// PURPOSE
//  Radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU, in the execute stage.
//  Directly downstream of the ID/EX pipeline register: consumes startE, funct3E,
//  forwarded rs1/rs2 values and waddrE.
//  Returns the product, a stall request for the earlier stages, and a one-cycle
//  clear pulse for the register's start-hold latch.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count equals XLEN
// PORTS
//  clk               in   1     rising-edge clock (the block's only clock)
//  rst_n             in   1     asynchronous, active-low reset
//  start             in   1     startE pulse from ID/EX register: begin multiply
//  flush             in   1     synchronous abort of in-flight op (FlushE / trap)
//  funct3            in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
//  op_a              in   XLEN  rs1 value (after forwarding)
//  op_b              in   XLEN  rs2 value (after forwarding)
//  waddr_in          in   5     destination register of the multiply
//  busy              out  1     state != IDLE
//  stall             out  1     freeze IF/ID/EX while multiply is in progress
//  done              out  1     one-cycle pulse: result valid
//  result            out  XLEN  selected product word
//  waddr_out         out  5     destination latched at start
//  reset_hold_start  out  1     pulse to ID/EX register clearing hold_start (= done)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; every output 0; internal registers 0.
//  States:
//  - IDLE: start & ~flush & funct3[2]==0 -> CALC. On that edge:
//    - latch |a|, |b| as magnitudes: a is signed for 001/010, b is signed for 001
//      (-2^(XLEN-1) magnitude fits unsigned);
//    - neg = sign_a ^ sign_b; acc = 0; count = XLEN; latch funct3 and waddr_in.
//    - funct3[2]=1 (div ops) -> start ignored, no state change.
//  - CALC: each edge, if mplier[0]: acc += mcand (2*XLEN bits); mcand <<= 1;
//    mplier >>= 1; count--. After the XLEN-th iteration -> DONE. No early exit
//    on zero operands.
//  - DONE: one cycle. prod = neg ? -acc : acc (2*XLEN-bit two's complement);
//    result = (funct3==000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]. done=1,
//    reset_hold_start=1. -> IDLE.
//  Timing:
//  - Latency: start sampled in cycle 0; CALC cycles 1..XLEN; done in cycle XLEN+1.
//  - stall = (IDLE & accepted start) | CALC; low in the DONE cycle so the
//    instruction advances with result.
//  Outputs:
//  - result/waddr_out are registered and hold until the next accepted start.
//  - done and reset_hold_start are pulses, never high two cycles in a row.
//  Boundary cases:
//  - start during CALC/DONE: ignored.
//  - flush in any state: -> IDLE next edge; no done, no reset_hold_start
//    (the ID/EX register clears its own latch on flush).
//  - flush and start in the same IDLE cycle: flush wins, no op accepted.
//  - flush in the DONE cycle: done still asserted that cycle (already committed).
//  - rst_n low mid-op: immediate IDLE; all outputs 0; op lost.
// TESTING
//  1. MUL a=7, b=6, start cycle 0 -> stall high cycles 0..32; done=1 only in
//     cycle 33; result=42; waddr_out=waddr_in.
//  2. MULH 0x80000000 x 0x80000000 -> 0x40000000; MUL of same -> 0x00000000.
//  3. a=b=0xFFFFFFFF: MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF;
//     MULHU -> 0xFFFFFFFE; MUL -> 0x00000001.
//  4. Second start at cycle 5 while busy -> ignored; single done at 33 with first result.
//     Flush at cycle 10 -> busy=0 in cycle 11, no done; next start accepted.
//  5. rst_n low at cycle 15 -> busy/stall/done/result=0 immediately.
//     After release, MUL 3 x 0xFFFFFFFB -> 0xFFFFFFF1.
//  6. start with funct3=100 -> busy stays 0, no done; back-to-back MULs
//     (start in cycle after done) -> each completes in XLEN+1 cycles.

Source files
------------

// File: rtl/iterative_mul_unit.sv
// -----------------------------------------------------------------------------
// iterative_mul_unit
//
// Radix-2 shift-add multiplier for the RV32M MUL / MULH / MULHSU / MULHU
// instructions, placed in the execute stage right after the ID/EX register.
// Operands are converted to magnitudes when the op is accepted. XLEN
// add-and-shift iterations then build the unsigned 2*XLEN-bit product. The
// sign is applied on the last iteration, so the selected result word is
// already registered when done pulses.
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   start             begin a multiply (startE from ID/EX)
//   flush             synchronous abort of any in-flight op
//   funct3            000 MUL, 001 MULH, 010 MULHSU, 011 MULHU (1xx ignored)
//   op_a, op_b        rs1 / rs2 values after forwarding
//   waddr_in          destination register of the multiply
//   busy              unit is not idle
//   stall             freeze IF/ID/EX while the multiply is in progress
//   done              one-cycle pulse, result valid
//   result            selected product word (held until replaced)
//   waddr_out         destination latched when the op was accepted
//   reset_hold_start  one-cycle pulse clearing the ID/EX start-hold latch
// -----------------------------------------------------------------------------
module iterative_mul_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      waddr_in,
   output logic            busy,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      waddr_out,
   output logic            reset_hold_start
);

   localparam int unsigned CW = $clog2(XLEN + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Magnitude of an operand. The most negative value maps onto itself, which
   // is the correct unsigned magnitude 2^(XLEN-1).
   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                 input logic            is_signed);
      magnitude = (is_signed && v[XLEN-1]) ? -v : v;
   endfunction

   // Two's-complement sign application on the full double-width product.
   function automatic logic [2*XLEN-1:0] apply_sign(input logic [2*XLEN-1:0] p,
                                                    input logic              neg);
      apply_sign = neg ? -p : p;
   endfunction

   state_t              state_q, state_nxt;
   logic [2*XLEN-1:0]   mcand_q;
   logic [XLEN-1:0]     mplier_q;
   logic [2*XLEN-1:0]   acc_q;
   logic [CW-1:0]       count_q;
   logic                neg_q;
   logic                low_word_q;
   logic [XLEN-1:0]     result_q;
   logic [4:0]          waddr_q;

   logic                accept;
   logic                a_signed, b_signed;
   logic                sign_a, sign_b;
   logic [XLEN-1:0]     mag_a, mag_b;
   logic [2*XLEN-1:0]   acc_nxt;
   logic [2*XLEN-1:0]   prod;
   logic [XLEN-1:0]     result_nxt;
   logic                last_iter;

   // Operand signedness: rs1 signed for MULH/MULHSU, rs2 signed for MULH only.
   always_comb begin
      a_signed = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
      b_signed = (funct3[1:0] == 2'b01);
      sign_a   = a_signed & op_a[XLEN-1];
      sign_b   = b_signed & op_b[XLEN-1];
      mag_a    = magnitude(op_a, a_signed);
      mag_b    = magnitude(op_b, b_signed);
   end

   // rst_n is folded in so stall cannot assert while the unit is held in reset.
   always_comb begin
      accept = rst_n & start & ~flush & ~funct3[2] & (state_q == S_IDLE);
   end

   // One iteration of the shift-add datapath and the final result selection.
   // On the last iteration the sign is applied to the updated accumulator,
   // so result is ready in the DONE cycle.
   always_comb begin
      acc_nxt    = acc_q + (mplier_q[0] ? mcand_q : '0);
      prod       = apply_sign(acc_nxt, neg_q);
      result_nxt = low_word_q ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      last_iter  = (count_q == CW'(1));
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) state_nxt = S_CALC;
         end
         S_CALC: begin
            if (flush)          state_nxt = S_IDLE;
            else if (last_iter) state_nxt = S_DONE;
         end
         S_DONE: begin
            // Already committed: a flush here changes nothing but the return.
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy             = (state_q != S_IDLE);
      stall            = accept | (state_q == S_CALC);
      done             = (state_q == S_DONE);
      reset_hold_start = (state_q == S_DONE);
      result           = result_q;
      waddr_out        = waddr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         count_q    <= '0;
         neg_q      <= 1'b0;
         low_word_q <= 1'b0;
         result_q   <= '0;
         waddr_q    <= '0;
      end else begin
         state_q <= state_nxt;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  mcand_q    <= {{XLEN{1'b0}}, mag_a};
                  mplier_q   <= mag_b;
                  acc_q      <= '0;
                  count_q    <= CW'(XLEN);
                  neg_q      <= sign_a ^ sign_b;
                  low_word_q <= (funct3[1:0] == 2'b00);
                  waddr_q    <= waddr_in;
               end
            end
            S_CALC: begin
               if (!flush) begin
                  acc_q    <= acc_nxt;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
                  count_q  <= count_q - CW'(1);
                  if (last_iter) result_q <= result_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iterative_mul_unit.sv
module tb_iterative_mul_unit;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic            flush;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [4:0]      waddr_in;
   logic            busy;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      waddr_out;
   logic            reset_hold_start;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] last_res;
   bit          hold_ok;

   iterative_mul_unit #(.XLEN(XLEN)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .flush            (flush),
      .funct3           (funct3),
      .op_a             (op_a),
      .op_b             (op_b),
      .waddr_in         (waddr_in),
      .busy             (busy),
      .stall            (stall),
      .done             (done),
      .result           (result),
      .waddr_out        (waddr_out),
      .reset_hold_start (reset_hold_start)
   );

   always #5 clk = ~clk;

   // Reference: exact product of the operands interpreted per the opcode.
   function automatic logic [31:0] ref_mul(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [63:0] ea, eb, p;
      ea = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
      eb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      return (f3 == 3'd0) ? p[31:0] : p[63:32];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One multiply from the start cycle (0) up to the done cycle (XLEN+1).
   // Optional disturbances: a second start, a flush or a reset in CALC cycle
   // N (0 = none), or a flush in the done cycle.
   task automatic run_op(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input int extra_start,
                         input int flush_cyc, input int rst_cyc, input bit flush_done);
      logic [31:0] exp_r;
      int          bad;
      bit          aborted;
      exp_r   = ref_mul(f3, a, b);
      bad     = 0;
      aborted = 0;
      @(negedge clk);
      check({tag, "_no_double_done"}, done, 0);
      if (hold_ok) check({tag, "_result_held"}, result, last_res);
      funct3 = f3; op_a = a; op_b = b; waddr_in = wa; start = 1; flush = 0;
      #1 check({tag, "_stall_c0"}, stall, 1);
      @(negedge clk);
      for (int i = 1; i <= XLEN; i++) begin
         if (aborted) begin
            if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || reset_hold_start !== 1'b0) bad++;
         end else if (busy !== 1'b1 || stall !== 1'b1 || done !== 1'b0 || reset_hold_start !== 1'b0) bad++;
         start = (i == extra_start);
         if (i == extra_start) begin op_a = ~a; op_b = b + 32'd1; waddr_in = ~wa; end
         flush = (i == flush_cyc);
         if (i == flush_cyc) aborted = 1;
         if (i == rst_cyc) begin
            rst_n = 0;
            #1;
            check({tag, "_rst_busy"}, busy, 0);
            check({tag, "_rst_stall"}, stall, 0);
            check({tag, "_rst_done"}, done, 0);
            check({tag, "_rst_result"}, result, 0);
            check({tag, "_rst_waddr"}, waddr_out, 0);
            aborted = 1;
         end
         @(negedge clk);
      end
      start = 0; flush = 0;
      check({tag, "_calc_window"}, bad, 0);
      if (aborted) begin
         check({tag, "_no_done"}, done, 0);
         check({tag, "_idle"}, busy, 0);
         hold_ok = 0;
      end else begin
         check({tag, "_done"}, done, 1);
         check({tag, "_rhs"}, reset_hold_start, 1);
         check({tag, "_stall_low"}, stall, 0);
         check({tag, "_result"}, result, exp_r);
         check({tag, "_waddr"}, waddr_out, wa);
         last_res = exp_r;
         hold_ok  = 1;
         if (flush_done) begin
            flush = 1;
            #1 check({tag, "_done_under_flush"}, done, 1);
            @(negedge clk);
            flush = 0;
            check({tag, "_idle_after_flush"}, busy, 0);
            check({tag, "_done_cleared"}, done, 0);
         end
      end
      if (rst_cyc > 0) begin
         rst_n    = 1;
         last_res = 32'd0;
         hold_ok  = 1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ill_bad;
      logic [2:0]  rf3;
      logic [31:0] ra, rb;
      rst_n = 0; start = 1; flush = 0; funct3 = 3'd0;
      op_a = 32'd5; op_b = 32'd5; waddr_in = 5'd1;
      hold_ok = 0; last_res = 32'd0;
      repeat (2) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_stall", stall, 0);
      check("reset_done", done, 0);
      check("reset_rhs", reset_hold_start, 0);
      check("reset_result", result, 0);
      check("reset_waddr", waddr_out, 0);
      start = 0;
      rst_n = 1;
      hold_ok = 1;

      run_op("mul_7x6", 3'd0, 32'd7, 32'd6, 5'd9, 0, 0, 0, 0);
      check("mul_7x6_const", result, 32'd42);

      run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3, 0, 0, 0, 0);
      check("mulh_min_const", result, 32'h4000_0000);
      run_op("mul_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 5'd4, 0, 0, 0, 0);
      check("mul_min_const", result, 32'h0000_0000);

      run_op("mulh_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0, 0, 0, 0);
      check("mulh_ff_const", result, 32'h0000_0000);
      run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0, 0, 0, 0);
      check("mulhsu_ff_const", result, 32'hFFFF_FFFF);
      run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0, 0, 0, 0);
      check("mulhu_ff_const", result, 32'hFFFF_FFFE);
      run_op("mul_ff", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 0, 0, 0, 0);
      check("mul_ff_const", result, 32'h0000_0001);

      run_op("busy_start", 3'd0, 32'd1234, 32'd5678, 5'd10, 5, 0, 0, 0);
      run_op("flush_c10", 3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd11, 0, 10, 0, 0);
      run_op("after_flush", 3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd12, 0, 0, 0, 0);
      run_op("flush_done", 3'd2, 32'hF000_000F, 32'h0000_0101, 5'd13, 0, 0, 0, 1);

      // flush and start together in IDLE: flush wins
      @(negedge clk);
      funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; start = 1; flush = 1;
      #1 check("flush_start_stall", stall, 0);
      @(negedge clk);
      start = 0; flush = 0;
      check("flush_start_busy", busy, 0);

      // division encodings are not taken
      @(negedge clk);
      funct3 = 3'd4; start = 1;
      #1 check("div_stall", stall, 0);
      @(negedge clk);
      start = 0; funct3 = 3'd0;
      ill_bad = 0;
      for (int i = 0; i < XLEN + 2; i++) begin
         if (busy !== 1'b0 || done !== 1'b0) ill_bad++;
         @(negedge clk);
      end
      check("div_ignored", ill_bad, 0);

      run_op("rst_c15", 3'd0, 32'd77, 32'd88, 5'd14, 0, 0, 15, 0);
      run_op("mul_3xneg5", 3'd0, 32'd3, 32'hFFFF_FFFB, 5'd15, 0, 0, 0, 0);
      check("mul_3xneg5_const", result, 32'hFFFF_FFF1);

      for (int k = 0; k < 20; k++) begin
         rf3 = 3'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: ra = 32'h8000_0000;
            1: ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 3))
            0: rb = 32'h7FFF_FFFF;
            1: rb = 32'd0;
            default: rb = $urandom;
         endcase
         run_op($sformatf("rand%0d", k), rf3, ra, rb, 5'($urandom_range(0, 31)), 0, 0, 0, 0);
      end

      @(negedge clk);
      check("final_idle", busy, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
